// File: rtl/pipe_pkg.sv
// Shared definitions for the segmented core's inter-stage pipeline registers.
// Contents:
//   NOP_INSTR        canonical bubble instruction (addi x0, x0, 0)
//   *_W              payload widths of each stage boundary
//   if_id_payload_t  IF/ID payload layout; instr sits in the low 32 bits so a
//                    bubble is simply NOP_INSTR zero-extended
//   IF_ID_FLUSH_VAL  flush/reset payload for the IF/ID instance
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned IF_ID_W  = 96;   // instr + pc + pc_next4
  localparam int unsigned ID_EX_W  = 160;  // pc + rs1 + rs2 + imm + ctrl
  localparam int unsigned EX_MEM_W = 104;  // alu result + store data + rd/ctrl
  localparam int unsigned MEM_WB_W = 72;   // wb data + pc + rd/ctrl

  typedef struct packed {
    logic [31:0] pc_next4;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_payload_t;

  localparam logic [IF_ID_W-1:0] IF_ID_FLUSH_VAL = {64'h0, NOP_INSTR};

endpackage

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with optional 2-entry skid buffer,
// synchronous flush inserting a bubble payload, and an occupancy count.
// Ports:
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-high reset
//   flush_i     synchronous flush: drop held entries and this cycle's upstream beat
//   up_valid_i  upstream beat present
//   up_ready_o  stage can accept a beat
//   up_data_i   upstream payload
//   dn_valid_o  main entry valid
//   dn_ready_i  downstream accepts
//   dn_data_o   main entry payload (FLUSH_VAL when invalid)
//   occ_o       number of held entries (0..2)
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W    = IF_ID_W,
  parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
  parameter bit                SKID_EN   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [DATA_W-1:0] dn_data_o,
  output logic [1:0]        occ_o
);

  logic              main_v_q;
  logic [DATA_W-1:0] main_data_q;
  logic [1:0]        occ_q;
  logic              acc;
  logic              drn;

  assign acc = up_valid_i & up_ready_o;
  assign drn = main_v_q & dn_ready_i;

  assign dn_valid_o = main_v_q;
  assign dn_data_o  = main_data_q;
  assign occ_o      = occ_q;

  if (SKID_EN) begin : g_skid
    logic              skid_v_q;
    logic [DATA_W-1:0] skid_data_q;
    logic              main_v_d;
    logic [DATA_W-1:0] main_data_d;
    logic              skid_v_d;
    logic [DATA_W-1:0] skid_data_d;

    // Depends only on state (and reset), so dn_ready_i never reaches up_ready_o.
    assign up_ready_o = ~rst_i & ~skid_v_q;

    always_comb begin
      main_v_d    = main_v_q;
      main_data_d = main_data_q;
      skid_v_d    = skid_v_q;
      skid_data_d = skid_data_q;
      if (flush_i) begin
        main_v_d    = 1'b0;
        main_data_d = FLUSH_VAL;
        skid_v_d    = 1'b0;
        skid_data_d = FLUSH_VAL;
      end else if (!main_v_q || drn) begin
        // Main slot frees up: the skid entry is older than any new beat.
        if (skid_v_q) begin
          main_v_d    = 1'b1;
          main_data_d = skid_data_q;
          skid_v_d    = 1'b0;
          skid_data_d = FLUSH_VAL;
        end else if (acc) begin
          main_v_d    = 1'b1;
          main_data_d = up_data_i;
        end else begin
          main_v_d    = 1'b0;
          main_data_d = FLUSH_VAL;
        end
      end else if (acc) begin
        skid_v_d    = 1'b1;
        skid_data_d = up_data_i;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        main_v_q    <= 1'b0;
        main_data_q <= FLUSH_VAL;
        skid_v_q    <= 1'b0;
        skid_data_q <= FLUSH_VAL;
        occ_q       <= 2'd0;
      end else begin
        main_v_q    <= main_v_d;
        main_data_q <= main_data_d;
        skid_v_q    <= skid_v_d;
        skid_data_q <= skid_data_d;
        occ_q       <= {1'b0, main_v_d} + {1'b0, skid_v_d};
      end
    end
  end else begin : g_noskid
    logic              main_v_d;
    logic [DATA_W-1:0] main_data_d;

    assign up_ready_o = ~rst_i & (~main_v_q | dn_ready_i);

    always_comb begin
      main_v_d    = main_v_q;
      main_data_d = main_data_q;
      if (flush_i) begin
        main_v_d    = 1'b0;
        main_data_d = FLUSH_VAL;
      end else if (acc) begin
        main_v_d    = 1'b1;
        main_data_d = up_data_i;
      end else if (drn) begin
        main_v_d    = 1'b0;
        main_data_d = FLUSH_VAL;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        main_v_q    <= 1'b0;
        main_data_q <= FLUSH_VAL;
        occ_q       <= 2'd0;
      end else begin
        main_v_q    <= main_v_d;
        main_data_q <= main_data_d;
        occ_q       <= {1'b0, main_v_d};
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a skid build (IF/ID flavour, bubble = NOP)
// and a non-skid build with default zero bubble.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int unsigned W = IF_ID_W;
  localparam logic [W-1:0] FV = IF_ID_FLUSH_VAL;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         up_valid;
  logic         up_ready;
  logic [W-1:0] up_data;
  logic         dn_valid;
  logic         dn_ready;
  logic [W-1:0] dn_data;
  logic [1:0]   occ;

  logic         n_up_valid;
  logic         n_up_ready;
  logic [W-1:0] n_up_data;
  logic         n_dn_valid;
  logic         n_dn_ready;
  logic [W-1:0] n_dn_data;
  logic [1:0]   n_occ;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] drained[$];
  logic         hold_pend = 1'b0;
  logic [W-1:0] hold_data;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DATA_W   (W),
    .FLUSH_VAL(FV),
    .SKID_EN  (1'b1)
  ) u_dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .flush_i   (flush),
    .up_valid_i(up_valid),
    .up_ready_o(up_ready),
    .up_data_i (up_data),
    .dn_valid_o(dn_valid),
    .dn_ready_i(dn_ready),
    .dn_data_o (dn_data),
    .occ_o     (occ)
  );

  pipe_stage_skid #(
    .DATA_W (W),
    .SKID_EN(1'b0)
  ) u_dut_noskid (
    .clk_i     (clk),
    .rst_i     (rst),
    .flush_i   (1'b0),
    .up_valid_i(n_up_valid),
    .up_ready_o(n_up_ready),
    .up_data_i (n_up_data),
    .dn_valid_o(n_dn_valid),
    .dn_ready_i(n_dn_ready),
    .dn_data_o (n_dn_data),
    .occ_o     (n_occ)
  );

  // Record every beat the skid build hands downstream.
  always @(posedge clk) begin
    if (!rst && dn_valid && dn_ready) drained.push_back(dn_data);
  end

  // Upstream protocol: payload stays put while a beat is offered but not taken.
  always @(posedge clk) begin
    if (!rst && hold_pend) begin
      assert (up_data == hold_data) else $error("upstream data changed while stalled");
    end
    hold_pend = up_valid & ~up_ready & ~rst & ~flush;
    hold_data = up_data;
  end

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_drained(input string tag, input logic [W-1:0] exp[$]);
    check_eq({tag, "_count"}, W'(drained.size()), W'(exp.size()));
    for (int i = 0; i < exp.size() && i < drained.size(); i++) begin
      check_eq($sformatf("%s_%0d", tag, i), drained[i], exp[i]);
    end
  endtask

  initial begin
    logic [W-1:0] beats[3];
    logic [W-1:0] exp_q[$];

    rst = 1'b1; flush = 1'b0;
    up_valid = 1'b0; up_data = '0; dn_ready = 1'b0;
    n_up_valid = 1'b0; n_up_data = '0; n_dn_ready = 1'b0;

    // Power-on reset
    #2;
    check_eq("por_dn_valid", dn_valid, 1'b0);
    check_eq("por_dn_data", dn_data, FV);
    check_eq("por_occ", occ, 2'd0);
    check_eq("por_up_ready", up_ready, 1'b0);
    step();
    rst = 1'b0;
    #1;
    check_eq("por_release_ready", up_ready, 1'b1);

    // Streaming at full rate
    beats[0] = 96'hA; beats[1] = 96'hB; beats[2] = 96'hC;
    drained.delete();
    dn_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      up_valid = 1'b1;
      up_data  = beats[i];
      step();
      check_eq($sformatf("stream_data_%0d", i), dn_data, beats[i]);
      check_eq($sformatf("stream_occ_%0d", i), occ, 2'd1);
      check_eq($sformatf("stream_ready_%0d", i), up_ready, 1'b1);
    end
    up_valid = 1'b0;
    step();
    check_eq("stream_empty_valid", dn_valid, 1'b0);
    check_eq("stream_empty_data", dn_data, FV);
    exp_q = '{96'hA, 96'hB, 96'hC};
    check_drained("stream_out", exp_q);

    // Stall fills the skid, release drains in order
    drained.delete();
    dn_ready = 1'b0;
    up_valid = 1'b1; up_data = 96'h1;
    step();
    check_eq("stall_a_data", dn_data, 96'h1);
    check_eq("stall_a_ready", up_ready, 1'b1);
    up_data = 96'h2;
    step();
    check_eq("stall_b_data", dn_data, 96'h1);
    check_eq("stall_b_occ", occ, 2'd2);
    check_eq("stall_b_ready", up_ready, 1'b0);
    up_data = 96'h3;
    step();
    check_eq("stall_c_data", dn_data, 96'h1);
    check_eq("stall_c_occ", occ, 2'd2);
    check_eq("stall_c_ready", up_ready, 1'b0);
    dn_ready = 1'b1;
    step();
    check_eq("release_a_data", dn_data, 96'h2);
    check_eq("release_a_occ", occ, 2'd1);
    check_eq("release_a_ready", up_ready, 1'b1);
    step();
    check_eq("release_b_data", dn_data, 96'h3);
    check_eq("release_b_occ", occ, 2'd1);
    up_valid = 1'b0;
    step();
    check_eq("release_c_valid", dn_valid, 1'b0);
    check_eq("release_c_occ", occ, 2'd0);
    exp_q = '{96'h1, 96'h2, 96'h3};
    check_drained("stall_out", exp_q);

    // Flush with both entries held and a beat offered
    drained.delete();
    dn_ready = 1'b0;
    up_valid = 1'b1; up_data = 96'h4;
    step();
    up_data = 96'h6;
    step();
    check_eq("flush_pre_occ", occ, 2'd2);
    up_data = 96'hF; flush = 1'b1;
    step();
    flush = 1'b0; up_valid = 1'b0;
    check_eq("flush_occ", occ, 2'd0);
    check_eq("flush_valid", dn_valid, 1'b0);
    check_eq("flush_data", dn_data, FV);
    check_eq("flush_ready", up_ready, 1'b1);
    // Flush on an empty stage discards the beat accepted that cycle
    dn_ready = 1'b1;
    up_valid = 1'b1; up_data = 96'hF; flush = 1'b1;
    step();
    flush = 1'b0; up_valid = 1'b0;
    check_eq("flush_acc_occ", occ, 2'd0);
    check_eq("flush_acc_valid", dn_valid, 1'b0);
    step();
    step();
    exp_q = {};
    check_drained("flush_out", exp_q);

    // Flush while the main entry drains
    drained.delete();
    dn_ready = 1'b0;
    up_valid = 1'b1; up_data = 96'h5;
    step();
    up_valid = 1'b0;
    check_eq("fdrain_pre_data", dn_data, 96'h5);
    dn_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("fdrain_occ", occ, 2'd0);
    check_eq("fdrain_valid", dn_valid, 1'b0);
    step();
    step();
    exp_q = '{96'h5};
    check_drained("fdrain_out", exp_q);

    // Reset asserted mid-stream with both entries held
    dn_ready = 1'b0;
    up_valid = 1'b1; up_data = 96'h7;
    step();
    up_data = 96'h8;
    step();
    up_valid = 1'b0;
    check_eq("rst_pre_occ", occ, 2'd2);
    rst = 1'b1;
    #1;
    check_eq("rst_dn_valid", dn_valid, 1'b0);
    check_eq("rst_dn_data", dn_data, FV);
    check_eq("rst_occ", occ, 2'd0);
    check_eq("rst_up_ready", up_ready, 1'b0);
    step();
    rst = 1'b0;
    #1;
    check_eq("rst_release_ready", up_ready, 1'b1);
    check_eq("rst_release_occ", occ, 2'd0);

    // Non-skid build: same streaming throughput
    n_dn_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_up_valid = 1'b1;
      n_up_data  = beats[i];
      step();
      check_eq($sformatf("ns_stream_data_%0d", i), n_dn_data, beats[i]);
      check_eq($sformatf("ns_stream_occ_%0d", i), n_occ, 2'd1);
      check_eq($sformatf("ns_stream_ready_%0d", i), n_up_ready, 1'b1);
    end
    n_up_valid = 1'b0;
    step();
    check_eq("ns_empty_valid", n_dn_valid, 1'b0);
    check_eq("ns_empty_data", n_dn_data, '0);

    // Non-skid build: ready follows dn_ready combinationally when full
    n_dn_ready = 1'b0;
    n_up_valid = 1'b1; n_up_data = 96'h21;
    step();
    n_up_data = 96'h22;
    check_eq("ns_stall_ready", n_up_ready, 1'b0);
    step();
    check_eq("ns_stall_occ", n_occ, 2'd1);
    check_eq("ns_stall_data", n_dn_data, 96'h21);
    n_dn_ready = 1'b1;
    #1;
    check_eq("ns_comb_ready", n_up_ready, 1'b1);
    step();
    check_eq("ns_release_data", n_dn_data, 96'h22);
    check_eq("ns_release_occ", n_occ, 2'd1);
    n_up_valid = 1'b0;
    step();
    check_eq("ns_final_valid", n_dn_valid, 1'b0);
    check_eq("ns_final_occ", n_occ, 2'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
